ram4k_fill_engine: RTL and testbench

- Sequencer directly upstream of the 4K x 16 RAM. It owns the RAM's in/address/load inputs and reads back its combinational out.
- When idle, it passes host accesses straight through to the RAM.
- On start, it writes a constant or incrementing pattern over an address range, optionally reads the range back to verify it, and reports the first mismatch.
- Used for memory clear at boot and for RAM self-test.

---
 rtl/ram4k_fill_engine.sv | 161 ++++++++++++++++
 tb/tb_ram4k_fill_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4k_fill_engine.sv
// Fill/verify sequencer in front of the 4K x 16 RAM. Host accesses pass through while idle.
// One word per cycle: count cycles of fill, count more when verifying, then a one-cycle DONE.
module ram4k_fill_engine #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] host_in,
  input  logic [ADDR_W-1:0] host_address,
  input  logic              host_load,
  output logic [DATA_W-1:0] host_out,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_address
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q;
  logic [DATA_W-1:0]   pattern_q;
  logic [ADDR_W-1:0]   cursor_q;
  logic [ADDR_W:0]     index_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic [ADDR_W-1:0]   cursor_d;
  logic [ADDR_W:0]     index_d;
  logic                last_word;
  logic [DATA_W-1:0]   exp_word;

  assign cursor_d  = cursor_q + ADDR_W'(1);
  assign index_d   = index_q + (ADDR_W + 1)'(1);
  assign last_word = (index_d == count_q);
  // Same rule drives the fill data and the verify comparison.
  assign exp_word  = pattern_q + (mode_q[0] ? DATA_W'(index_q) : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      pattern_q  <= '0;
      cursor_q   <= '0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            base_q     <= base;
            count_q    <= count;
            pattern_q  <= pattern;
            cursor_q   <= base;
            index_q    <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            if (count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
              busy_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          cursor_q <= cursor_d;
          index_q  <= index_d;
          if (last_word) begin
            if (mode_q[1]) begin
              state_q  <= S_VERIFY;
              cursor_q <= base_q;
              index_q  <= '0;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_VERIFY: begin
          cursor_q <= cursor_d;
          index_q  <= index_d;
          // Only the first mismatch is recorded; the scan always runs to the end.
          if ((ram_out != exp_word) && !error_q) begin
            error_q    <= 1'b1;
            err_addr_q <= cursor_q;
          end
          if (last_word) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_in      = host_in;
    ram_address = host_address;
    ram_load    = 1'b0;
    host_out    = '0;
    case (state_q)
      S_IDLE: begin
        ram_load = host_load;
        host_out = ram_out;
      end
      S_FILL: begin
        ram_in      = exp_word;
        ram_address = cursor_q;
        ram_load    = 1'b1;
      end
      S_VERIFY: begin
        ram_in      = exp_word;
        ram_address = cursor_q;
      end
      S_DONE: begin
        host_out = ram_out;
      end
      default: begin
        ram_load = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_address = err_addr_q;

endmodule

// File: tb/tb_ram4k_fill_engine.sv
// Bench for ram4k_fill_engine: behavioural RAM with read-corruption hooks, table vectors,
// hand-written corner sequences and randomized operations against an array-based reference.
module tb_ram4k_fill_engine;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;
  localparam int LIMIT = 9000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [DW-1:0] pattern;
  logic [DW-1:0] host_in;
  logic [AW-1:0] host_address;
  logic          host_load;
  logic [DW-1:0] host_out;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [DW-1:0] ram_out;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_address;

  ram4k_fill_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(rst), .start(start), .mode(mode), .base(base), .count(count),
    .pattern(pattern), .host_in(host_in), .host_address(host_address),
    .host_load(host_load), .host_out(host_out), .ram_in(ram_in),
    .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out),
    .busy(busy), .done(done), .error(error), .err_address(err_address)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          mem_clr;
  logic          cor_en0, cor_en1;
  logic [AW-1:0] cor_a0, cor_a1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end

  // Corrupted cells read back with flipped bits; stored contents stay intact.
  assign ram_out = mem[ram_address] ^
                   (((cor_en0 && ram_address == cor_a0) || (cor_en1 && ram_address == cor_a1))
                    ? 16'h8001 : 16'h0000);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mem_check(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_mem_bad_words(first@%0h)", name, first), bad, 0);
  endtask

  task automatic model_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] c,
                          input logic [DW-1:0] p, output logic e_err, output logic [AW-1:0] e_ea);
    logic [AW-1:0] a;
    e_err = 1'b0;
    e_ea  = '0;
    for (int i = 0; i < int'(c); i++) begin
      a = AW'((int'(b) + i) % DEPTH);
      ref_mem[a] = p + (m[0] ? DW'(i) : DW'(0));
      if (m[1] && !e_err && ((cor_en0 && a == cor_a0) || (cor_en1 && a == cor_a1))) begin
        e_err = 1'b1;
        e_ea  = a;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] c,
                        input logic [DW-1:0] p, input logic interfere,
                        output int lat, output int busy_cyc, output int load_cyc,
                        output int hout_nz, output logic d_err, output logic [AW-1:0] d_ea,
                        output logic done_after);
    @(negedge clk);
    start = 1'b1; mode = m; base = b; count = c; pattern = p; host_load = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Scramble the launch inputs: the engine must use the values captured at start.
    mode = 2'($urandom); base = AW'($urandom); count = (AW + 1)'($urandom); pattern = DW'($urandom);
    lat = 1; busy_cyc = 0; load_cyc = 0; hout_nz = 0;
    while (1) begin
      if (busy) busy_cyc++;
      if (ram_load) load_cyc++;
      if (busy && host_out != '0) hout_nz++;
      if (interfere) begin
        if (busy) begin
          host_load = 1'b1; host_address = 12'h300; host_in = 16'h5555;
          start = 1'b1; base = 12'h400; count = 13'd3; mode = 2'b01;
        end else begin
          host_load = 1'b0; start = 1'b0;
        end
      end
      if (done || lat >= LIMIT) break;
      lat++;
      @(negedge clk);
    end
    d_err = error;
    d_ea  = err_address;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    host_address = a; host_in = d; host_load = 1'b1;
    @(negedge clk);
    host_load = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    host_address = a; host_load = 1'b0;
    #1;
    d = host_out;
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [DW-1:0] pat;
    logic          ce0;
    logic [AW-1:0] ca0;
    logic          ce1;
    logic [AW-1:0] ca1;
    int            lat;
    int            busy_cyc;
    logic          err;
    logic [AW-1:0] ea;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, bc, lc, hnz, iv;
    logic d_err, e_err, d_after;
    logic [AW-1:0] d_ea, e_ea, ra;
    logic [DW-1:0] rd;
    logic [1:0] m;
    logic [AW-1:0] b;
    logic [AW:0] c;
    logic [DW-1:0] p;

    tbl[0] = '{2'b00, 12'h100, 13'd4, 16'hBEEF, 1'b0, 12'h000, 1'b0, 12'h000, 5,  4,  1'b0, 12'h000};
    tbl[1] = '{2'b11, 12'hFFE, 13'd4, 16'hFFFF, 1'b0, 12'h000, 1'b0, 12'h000, 9,  8,  1'b0, 12'h000};
    tbl[2] = '{2'b10, 12'h100, 13'd8, 16'h5A5A, 1'b1, 12'h102, 1'b0, 12'h000, 17, 16, 1'b1, 12'h102};
    tbl[3] = '{2'b01, 12'h7F0, 13'd0, 16'h1111, 1'b0, 12'h000, 1'b0, 12'h000, 1,  0,  1'b0, 12'h000};
    tbl[4] = '{2'b11, 12'hFFD, 13'd6, 16'h0010, 1'b1, 12'h002, 1'b1, 12'h001, 13, 12, 1'b1, 12'h001};

    rst = 1'b1; mem_clr = 1'b1; start = 1'b0; mode = '0; base = '0; count = '0; pattern = '0;
    host_in = '0; host_address = '0; host_load = 1'b0;
    cor_en0 = 1'b0; cor_en1 = 1'b0; cor_a0 = '0; cor_a1 = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_address", err_address, 0);
    chk("rst_ram_load", ram_load, 0);
    mem_clr = 1'b0;
    rst = 1'b0;

    // Host passthrough
    host_write(12'h0A5, 16'h1234);
    ref_mem[12'h0A5] = 16'h1234;
    host_read(12'h0A5, rd);
    chk("pass_host_out", rd, 16'h1234);
    chk("pass_busy", busy, 0);
    chk("pass_done", done, 0);

    for (int t = 0; t < 5; t++) begin
      cor_en0 = tbl[t].ce0; cor_a0 = tbl[t].ca0;
      cor_en1 = tbl[t].ce1; cor_a1 = tbl[t].ca1;
      model_op(tbl[t].mode, tbl[t].base, tbl[t].cnt, tbl[t].pat, e_err, e_ea);
      run_op(tbl[t].mode, tbl[t].base, tbl[t].cnt, tbl[t].pat, 1'b0,
             lat, bc, lc, hnz, d_err, d_ea, d_after);
      cor_en0 = 1'b0; cor_en1 = 1'b0;
      chk($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      chk($sformatf("tbl%0d_busy_cycles", t), bc, tbl[t].busy_cyc);
      chk($sformatf("tbl%0d_load_cycles", t), lc, tbl[t].cnt);
      chk($sformatf("tbl%0d_done_one_cycle", t), d_after, 0);
      chk($sformatf("tbl%0d_error", t), d_err, tbl[t].err);
      chk($sformatf("tbl%0d_err_address", t), d_ea, tbl[t].ea);
      mem_check($sformatf("tbl%0d", t));
      if (t == 1) begin
        host_read(12'hFFE, rd); chk("wrap_rd_ffe", rd, 16'hFFFF);
        host_read(12'hFFF, rd); chk("wrap_rd_fff", rd, 16'h0000);
        host_read(12'h000, rd); chk("wrap_rd_000", rd, 16'h0001);
        host_read(12'h001, rd); chk("wrap_rd_001", rd, 16'h0002);
      end
    end

    // Host writes and start pulses while busy must have no effect
    model_op(2'b00, 12'h200, 13'd8, 16'hAAAA, e_err, e_ea);
    run_op(2'b00, 12'h200, 13'd8, 16'hAAAA, 1'b1, lat, bc, lc, hnz, d_err, d_ea, d_after);
    host_load = 1'b0; start = 1'b0;
    chk("intf_latency", lat, 9);
    chk("intf_busy_cycles", bc, 8);
    chk("intf_host_out_zero", hnz, 0);
    chk("intf_done_one_cycle", d_after, 0);
    mem_check("intf");

    // Reset in the middle of a fill
    host_address = 12'h0A5;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; base = 12'h800; count = 13'd100; pattern = 16'h4000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ram_load", ram_load, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_idle_addr", ram_address, 12'h0A5);
    for (int i = 0; i < 4; i++) ref_mem[12'h800 + i] = 16'h4000 + DW'(i);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stays_idle", busy, 0);
    mem_check("midrst");

    // Randomized operations against the reference array
    for (int r = 0; r < 20; r++) begin
      m = 2'($urandom_range(0, 3));
      b = AW'($urandom);
      c = (r == 0) ? 13'd4096 : (AW + 1)'($urandom_range(0, 40));
      if (r == 0) m[1] = 1'b1;
      p = DW'($urandom);
      cor_en0 = 1'b0; cor_en1 = 1'b0;
      if (c != 0 && $urandom_range(0, 1) == 1) begin
        cor_en0 = 1'b1;
        cor_a0  = AW'((int'(b) + int'($urandom_range(0, int'(c) - 1))) % DEPTH);
        cor_en1 = 1'($urandom_range(0, 1));
        cor_a1  = AW'($urandom);
      end
      model_op(m, b, c, p, e_err, e_ea);
      run_op(m, b, c, p, 1'b0, lat, bc, lc, hnz, d_err, d_ea, d_after);
      cor_en0 = 1'b0; cor_en1 = 1'b0;
      iv = int'(c) * (m[1] ? 2 : 1);
      chk($sformatf("rnd%0d_latency", r), lat, iv + 1);
      chk($sformatf("rnd%0d_busy_cycles", r), bc, iv);
      chk($sformatf("rnd%0d_load_cycles", r), lc, c);
      chk($sformatf("rnd%0d_done_one_cycle", r), d_after, 0);
      chk($sformatf("rnd%0d_error", r), d_err, e_err);
      chk($sformatf("rnd%0d_err_address", r), d_ea, e_ea);
      mem_check($sformatf("rnd%0d", r));
      ra = AW'($urandom);
      host_read(ra, rd);
      chk($sformatf("rnd%0d_host_read", r), rd, ref_mem[ra]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
